// File: rtl/alu_control.sv
// ALU control decoder for the 16-bit MIPS-style CPU: maps the main-control ALU opcode
// and the R-type function field to a registered 3-bit ALU operation select.
module alu_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] alu_op,
   input  logic [2:0] func,
   output logic [2:0] alu_ctrl,
   output logic       illegal_func
);

   // ALU operation encoding seen by the datapath; 3'b111 is reserved
   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_ADD = 3'b001,
      ALU_SUB = 3'b010,
      ALU_XOR = 3'b011,
      ALU_NOR = 3'b100,
      ALU_OR  = 3'b101,
      ALU_SLT = 3'b110
   } alu_sel_e;

   // Main-control opcodes
   typedef enum logic [2:0] {
      OP_MEM    = 3'b000,
      OP_NORI   = 3'b001,
      OP_BRANCH = 3'b010,
      OP_ANDI   = 3'b011,
      OP_RTYPE  = 3'b100,
      OP_SLTI   = 3'b101,
      OP_ADDI   = 3'b110,
      OP_ORI    = 3'b111
   } alu_op_e;

   alu_sel_e ctrl_next;
   logic     illegal_next;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a
      // value unassigned and no latch is inferred.
      ctrl_next    = ALU_ADD;
      illegal_next = 1'b0;
      case (alu_op)
         OP_MEM:    ctrl_next = ALU_ADD;
         OP_NORI:   ctrl_next = ALU_NOR;
         OP_BRANCH: ctrl_next = ALU_SUB;
         OP_ANDI:   ctrl_next = ALU_AND;
         OP_SLTI:   ctrl_next = ALU_SLT;
         OP_ADDI:   ctrl_next = ALU_ADD;
         OP_ORI:    ctrl_next = ALU_OR;
         OP_RTYPE: begin
            case (func)
               3'b000:  ctrl_next = ALU_AND;
               3'b001:  ctrl_next = ALU_ADD;
               3'b010:  ctrl_next = ALU_SUB;
               3'b011:  ctrl_next = ALU_XOR;
               3'b100:  ctrl_next = ALU_NOR;
               3'b101:  ctrl_next = ALU_OR;
               3'b110:  ctrl_next = ALU_SLT;
               // Undefined function: fall back to a harmless ADD and raise the flag
               default: begin
                  ctrl_next    = ALU_ADD;
                  illegal_next = 1'b1;
               end
            endcase
         end
         default:   ctrl_next = ALU_ADD;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (reset) begin
         alu_ctrl     <= ALU_ADD;
         illegal_func <= 1'b0;
      end else begin
         alu_ctrl     <= ctrl_next;
         illegal_func <= illegal_next;
      end
   end

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: a table-based reference model feeds a scoreboard
// queue at drive time; entries are popped and compared one clock later.
module tb_alu_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] alu_op;
   logic [2:0] func;
   logic [2:0] alu_ctrl;
   logic       illegal_func;

   typedef struct packed {
      logic       illegal;
      logic [2:0] ctrl;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_exp;
   int   n_checks = 0;
   int   n_errors = 0;

   // Non-R-type opcode -> ALU select; entry 4 (R-type) is never used
   logic [2:0] itype_tbl [8] = '{3'b001, 3'b100, 3'b010, 3'b000,
                                 3'b000, 3'b110, 3'b001, 3'b101};

   alu_control dut (
      .clk          (clk),
      .reset        (reset),
      .alu_op       (alu_op),
      .func         (func),
      .alu_ctrl     (alu_ctrl),
      .illegal_func (illegal_func)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got illegal=%b ctrl=%b, expected illegal=%b ctrl=%b",
                  tag, got[3], got[2:0], exp[3], exp[2:0]);
      end
   endtask

   function automatic exp_t model(input logic r, input logic [2:0] op, input logic [2:0] fn);
      exp_t e;
      if (r)                 e = '{illegal: 1'b0, ctrl: 3'b001};
      else if (op != 3'b100) e = '{illegal: 1'b0, ctrl: itype_tbl[op]};
      else if (fn == 3'b111) e = '{illegal: 1'b1, ctrl: 3'b001};
      else                   e = '{illegal: 1'b0, ctrl: fn};
      return e;
   endfunction

   // Drive on the falling edge, compare just after the following rising edge
   task automatic step(input string tag, input logic r, input logic [2:0] op,
                       input logic [2:0] fn);
      exp_t e;
      @(negedge clk);
      reset  = r;
      alu_op = op;
      func   = fn;
      sb_q.push_back(model(r, op, fn));
      @(posedge clk);
      #1;
      e        = sb_q.pop_front();
      last_exp = e;
      check(tag, {illegal_func, alu_ctrl}, e);
   endtask

   initial begin
      reset  = 1'b1;
      alu_op = 3'b100;
      func   = 3'b010;

      // Reset held two cycles with an R-type SUB on the inputs
      step("reset0", 1'b1, 3'b100, 3'b010);
      step("reset1", 1'b1, 3'b100, 3'b010);
      step("release", 1'b0, 3'b100, 3'b010);

      // I-type sweep with func held at 110
      step("itype_addi", 1'b0, 3'b110, 3'b110);
      step("itype_andi", 1'b0, 3'b011, 3'b110);
      step("itype_ori",  1'b0, 3'b111, 3'b110);
      step("itype_nori", 1'b0, 3'b001, 3'b110);
      step("itype_beq",  1'b0, 3'b010, 3'b110);
      step("itype_slti", 1'b0, 3'b101, 3'b110);
      step("itype_mem",  1'b0, 3'b000, 3'b110);

      // R-type sweep over the defined function codes
      for (int f = 0; f < 7; f++)
         step($sformatf("rtype_f%0d", f), 1'b0, 3'b100, 3'(f));

      // Undefined function, then the same func under a non-R-type opcode
      step("illegal_func", 1'b0, 3'b100, 3'b111);
      step("andi_f111",    1'b0, 3'b011, 3'b111);

      // Inputs changed mid-cycle must not reach the outputs before the next edge
      step("pre_hold", 1'b0, 3'b010, 3'b000);
      #2;
      alu_op = 3'b100;
      func   = 3'b111;
      #1;
      check("hold_midcycle", {illegal_func, alu_ctrl}, last_exp);

      // Reset wins over an ORI decode in the same cycle
      step("reset_prio", 1'b1, 3'b111, 3'b000);
      step("after_prio", 1'b0, 3'b111, 3'b000);

      // Random traffic with roughly 5% reset cycles
      for (int i = 0; i < 1000; i++)
         step("random", ($urandom_range(99) < 5), 3'($urandom_range(7)),
              3'($urandom_range(7)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
